// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and encodings: FSM states, HLT opcode, default bubble word.
// No logic; imported by the fetch stage and its IF/ID register.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_WAIT_REDIR = 2'd1,
        ST_HALT       = 2'd2
    } fetch_state_t;

    localparam logic [3:0]  HLT_OPCODE  = 4'hF;
    localparam logic [15:0] NOP_DEFAULT = 16'h0000;

    function automatic logic is_hlt(input logic [3:0] opcode);
        return opcode == HLT_OPCODE;
    endfunction

endpackage

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register; one cycle from load inputs to outputs.
// flush beats hold beats load; with none asserted the contents are kept.
module fetch_ifid_reg
    import fetch_pkg::*;
#(
    parameter logic [15:0] NOP_INSTR = NOP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        flush,
    input  logic        hold,
    input  logic [15:0] load_instr,
    input  logic [15:0] load_pc_plus2,
    output logic [15:0] instr,
    output logic [15:0] pc_plus2,
    output logic        valid
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr    <= NOP_INSTR;
            pc_plus2 <= 16'h0000;
            valid    <= 1'b0;
        end else if (flush) begin
            instr    <= NOP_INSTR;
            valid    <= 1'b0;
        end else if (hold) begin
            instr    <= instr;
        end else if (load) begin
            instr    <= load_instr;
            pc_plus2 <= load_pc_plus2;
            valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, redirect/halt FSM and IF/ID register; hits reach IF/ID next edge.
// I-cache miss or decode stall holds the PC; icache_addr never moves while a miss is in flight.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = NOP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] icache_addr,
    output logic        icache_enable,
    input  logic [15:0] icache_data,
    input  logic        icache_stall,
    input  logic        stall_id,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] ifid_instr,
    output logic [15:0] ifid_pc_plus2,
    output logic        ifid_valid,
    output logic        halted
);

    fetch_state_t state;
    logic [15:0]  pc;
    logic [15:0]  pending;
    logic [15:0]  pc_plus2;
    logic [15:0]  target;
    logic         ifid_load;
    logic         ifid_flush;
    logic         ifid_hold;

    assign pc_plus2      = pc + 16'd2;
    assign target        = redirect_pc & 16'hFFFE;
    assign icache_addr   = pc;
    assign icache_enable = (state != ST_HALT);
    assign halted        = (state == ST_HALT);

    always_comb begin
        ifid_load  = 1'b0;
        ifid_flush = 1'b0;
        ifid_hold  = 1'b0;
        if (redirect)
            ifid_flush = 1'b1;
        else if (stall_id)
            ifid_hold = 1'b1;
        else if (state == ST_RUN && !icache_stall)
            ifid_load = 1'b1;
        else
            ifid_flush = 1'b1;
    end

    // A redirect during a miss parks the target so the fill address stays stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_RUN;
            pc      <= RESET_PC;
            pending <= 16'h0000;
        end else if (redirect) begin
            if (!icache_stall) begin
                pc    <= target;
                state <= ST_RUN;
            end else begin
                pending <= target;
                state   <= ST_WAIT_REDIR;
            end
        end else if (!stall_id) begin
            case (state)
                ST_RUN: begin
                    if (!icache_stall) begin
                        if (is_hlt(icache_data[15:12]))
                            state <= ST_HALT;
                        else
                            pc <= pc_plus2;
                    end
                end
                ST_WAIT_REDIR: begin
                    if (!icache_stall) begin
                        pc    <= pending;
                        state <= ST_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    fetch_ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid (
        .clk           (clk),
        .rst           (rst),
        .load          (ifid_load),
        .flush         (ifid_flush),
        .hold          (ifid_hold),
        .load_instr    (icache_data),
        .load_pc_plus2 (pc_plus2),
        .instr         (ifid_instr),
        .pc_plus2      (ifid_pc_plus2),
        .valid         (ifid_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Fetch stage bench: directed scenarios plus random traffic against a rule-level model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] icache_addr;
    logic        icache_enable;
    logic [15:0] icache_data;
    logic        icache_stall;
    logic        stall_id;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc_plus2;
    logic        ifid_valid;
    logic        halted;

    int n_vec = 0;
    int n_bad = 0;

    // reference model state
    logic [15:0] m_pc;
    logic [15:0] m_pend;
    bit          m_wait;
    bit          m_halt;
    logic [15:0] m_instr;
    logic [15:0] m_pc2;
    bit          m_valid;

    logic [15:0] hlt_addr = 16'h0001;
    bit          rand_hlt = 1'b0;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .icache_addr   (icache_addr),
        .icache_enable (icache_enable),
        .icache_data   (icache_data),
        .icache_stall  (icache_stall),
        .stall_id      (stall_id),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc),
        .ifid_instr    (ifid_instr),
        .ifid_pc_plus2 (ifid_pc_plus2),
        .ifid_valid    (ifid_valid),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] imem(input logic [15:0] a);
        logic [15:0] v;
        v = (a * 16'h9E37) ^ 16'h3C5A;
        if (a == hlt_addr) return 16'hF000;
        if (rand_hlt && a[6:1] == 6'd0) return {4'hF, v[11:0]};
        if (v[15:12] == 4'hF) v[15:12] = 4'h7;
        return v;
    endfunction

    function automatic void model_reset();
        m_pc = 16'h0000; m_pend = 16'h0000; m_wait = 0; m_halt = 0;
        m_instr = 16'h0000; m_pc2 = 16'h0000; m_valid = 0;
    endfunction

    function automatic void bubble();
        m_instr = 16'h0000;
        m_valid = 0;
    endfunction

    function automatic void model_step(input bit rd, input logic [15:0] rpc,
                                       input bit st_i, input bit st_id,
                                       input logic [15:0] data);
        if (rd) begin
            bubble();
            m_halt = 0;
            if (!st_i) begin
                m_pc = {rpc[15:1], 1'b0};
                m_wait = 0;
            end else begin
                m_pend = {rpc[15:1], 1'b0};
                m_wait = 1;
            end
        end else if (st_id) begin
            // everything frozen
        end else if (m_wait) begin
            bubble();
            if (!st_i) begin
                m_pc = m_pend;
                m_wait = 0;
            end
        end else if (m_halt || st_i) begin
            bubble();
        end else begin
            m_instr = data;
            m_pc2 = m_pc + 16'd2;
            m_valid = 1;
            if (data[15:12] == 4'hF) m_halt = 1;
            else m_pc = m_pc + 16'd2;
        end
    endfunction

    task automatic compare_all();
        chk("icache_addr", icache_addr, m_pc);
        chk("icache_enable", {15'd0, icache_enable}, {15'd0, !m_halt});
        chk("halted", {15'd0, halted}, {15'd0, m_halt});
        chk("ifid_valid", {15'd0, ifid_valid}, {15'd0, m_valid});
        chk("ifid_instr", ifid_instr, m_instr);
        chk("ifid_pc_plus2", ifid_pc_plus2, m_pc2);
    endtask

    task automatic cyc(input bit rd, input logic [15:0] rpc, input bit st_i, input bit st_id);
        logic [15:0] d;
        redirect     = rd;
        redirect_pc  = rpc;
        icache_stall = st_i;
        stall_id     = st_id;
        d = st_i ? 16'($urandom) : imem(icache_addr);
        icache_data  = d;
        @(posedge clk);
        model_step(rd, rpc, st_i, st_id, d);
        #1;
        compare_all();
    endtask

    initial begin
        rst = 1'b1;
        redirect = 0; redirect_pc = 0; icache_stall = 0; stall_id = 0; icache_data = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;

        // consecutive hits from reset
        cyc(0, 0, 0, 0); chk("hit0_pc2", ifid_pc_plus2, 16'h0002);
        cyc(0, 0, 0, 0); chk("hit1_pc2", ifid_pc_plus2, 16'h0004);
        cyc(0, 0, 0, 0); chk("hit2_pc2", ifid_pc_plus2, 16'h0006);
        chk("hit2_valid", {15'd0, ifid_valid}, 16'd1);

        // four-cycle miss at 0004
        cyc(1, 16'h0004, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 1, 0);
            chk("miss_addr", icache_addr, 16'h0004);
            chk("miss_bubble", {15'd0, ifid_valid}, 16'd0);
        end
        cyc(0, 0, 0, 0);
        chk("miss_fill_pc2", ifid_pc_plus2, 16'h0006);
        chk("miss_fill_instr", ifid_instr, imem(16'h0004));

        // redirect on second miss cycle
        cyc(0, 0, 1, 0);
        cyc(1, 16'h0040, 1, 0);
        chk("redir_miss_addr", icache_addr, 16'h0006);
        cyc(0, 0, 1, 0);
        chk("redir_miss_addr2", icache_addr, 16'h0006);
        cyc(0, 0, 0, 0);
        chk("redir_discard", {15'd0, ifid_valid}, 16'd0);
        chk("redir_new_addr", icache_addr, 16'h0040);
        cyc(0, 0, 0, 0);
        chk("redir_fetch_pc2", ifid_pc_plus2, 16'h0042);

        // decode stall then redirect during stall
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        chk("sid_pc2_held", ifid_pc_plus2, 16'h0044);
        chk("sid_addr_held", icache_addr, 16'h0044);
        cyc(1, 16'h0100, 0, 1);
        chk("sid_redir_addr", icache_addr, 16'h0100);

        // halt and exit
        hlt_addr = 16'h000A;
        cyc(1, 16'h000A, 0, 0);
        cyc(0, 0, 0, 0);
        chk("hlt_halted", {15'd0, halted}, 16'd1);
        chk("hlt_enable", {15'd0, icache_enable}, 16'd0);
        chk("hlt_instr", ifid_instr, 16'hF000);
        cyc(0, 0, 0, 0);
        chk("hlt_pc", icache_addr, 16'h000A);
        cyc(1, 16'h0020, 0, 0);
        cyc(0, 0, 0, 0);
        chk("hlt_exit_pc2", ifid_pc_plus2, 16'h0022);
        hlt_addr = 16'h0001;

        // wrap at FFFE, odd redirect target
        cyc(1, 16'hFFFF, 0, 0);
        chk("odd_target", icache_addr, 16'hFFFE);
        cyc(0, 0, 0, 0);
        chk("wrap_pc2", ifid_pc_plus2, 16'h0000);
        chk("wrap_addr", icache_addr, 16'h0000);

        // reset mid-miss takes effect before the next edge
        cyc(0, 0, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(0, 0, 0, 0);
        chk("post_rst_pc2", ifid_pc_plus2, 16'h0002);

        // random traffic
        rand_hlt = 1'b1;
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom % 8) == 0, 16'($urandom), ($urandom % 4) == 0, ($urandom % 6) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
